// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier, N CALC cycles per product.
// Signed operands are multiplied as magnitudes and the sign is applied when P is loaded.
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | one multiplier bit per cycle, LSB first
//   DONE  | P valid for one cycle; start here chains the next op
module mult_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   X,
    input  logic [N-1:0]   Y,
    input  logic           signed_mode,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] p_q, p_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic           sign_q, sign_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   x_mag, y_mag;
    logic [2*N-1:0] sum;

    // -2^(N-1) negates to itself, which read unsigned is exactly its magnitude
    always_comb begin
        x_mag = (signed_mode && X[N-1]) ? (~X + N'(1)) : X;
        y_mag = (signed_mode && Y[N-1]) ? (~Y + N'(1)) : Y;
        sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        p_d      = p_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = CALC;
                    mcand_d  = {{N{1'b0}}, x_mag};
                    mplier_d = y_mag;
                    sign_d   = signed_mode & (X[N-1] ^ Y[N-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            CALC: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    p_d     = sign_q ? (~sum + (2*N)'(1)) : sum;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            p_q      <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign P    = p_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed table, multi-cycle corner sequences, exhaustive N=4 and random N=8
// sweeps against an integer-arithmetic reference product.
module tb_mult_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0, sm4 = 1'b0, busy4, done4;
    logic [3:0] x4 = '0, y4 = '0;
    logic [7:0] p4;

    logic        start8 = 1'b0, sm8 = 1'b0, busy8, done8;
    logic [7:0]  x8 = '0, y8 = '0;
    logic [15:0] p8;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mult_seq #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .X(x4), .Y(y4),
        .signed_mode(sm4), .busy(busy4), .done(done4), .P(p4)
    );

    mult_seq #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .X(x8), .Y(y8),
        .signed_mode(sm8), .busy(busy8), .done(done8), .P(p8)
    );

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       sm;
        logic [7:0] exp_p;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain integer multiply of the operands as the mode interprets them.
    function automatic logic [31:0] ref_prod(input int n, input logic [15:0] x,
                                             input logic [15:0] y, input logic sm);
        longint a, b, prod, mask;
        a = longint'(x);
        b = longint'(y);
        if (sm && x[n-1]) a = a - (longint'(1) << n);
        if (sm && y[n-1]) b = b - (longint'(1) << n);
        prod = a * b;
        mask = (longint'(1) << (2 * n)) - 1;
        return 32'(prod & mask);
    endfunction

    // Called just after a negedge with the DUT in IDLE or DONE; returns at the negedge where done is seen.
    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic sm,
                       output logic [7:0] p, output int lat, output int busy_n);
        start4 = 1'b1; x4 = x; y4 = y; sm4 = sm;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom); sm4 = 1'($urandom);
        lat = 0; busy_n = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy4) busy_n++;
            if (done4) begin lat = i; break; end
            @(negedge clk);
        end
        p = p4;
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic sm,
                       output logic [15:0] p, output int lat);
        start8 = 1'b1; x8 = x; y8 = y; sm8 = sm;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); sm8 = 1'($urandom);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            if (done8) begin lat = i; break; end
            @(negedge clk);
        end
        p = p8;
    endtask

    initial begin
        logic [7:0]  p;
        logic [15:0] pw;
        logic [7:0]  held;
        int lat, bn, first_done, second_done, cyc, late_done;
        logic [7:0] rx, ry;
        logic       rsm;

        vecs[0]  = '{4'b0010, 4'b0100, 1'b0, 8'h08};
        vecs[1]  = '{4'b1111, 4'b0011, 1'b0, 8'h2D};
        vecs[2]  = '{4'b1111, 4'b0011, 1'b1, 8'hFD};
        vecs[3]  = '{4'b1000, 4'b1000, 1'b1, 8'h40};
        vecs[4]  = '{4'b1000, 4'b0111, 1'b1, 8'hC8};
        vecs[5]  = '{4'b0110, 4'b0110, 1'b0, 8'h24};
        vecs[6]  = '{4'b1111, 4'b1111, 1'b0, 8'hE1};
        vecs[7]  = '{4'b0111, 4'b0111, 1'b1, 8'h31};
        vecs[8]  = '{4'b0000, 4'b1111, 1'b1, 8'h00};
        vecs[9]  = '{4'b1111, 4'b1111, 1'b1, 8'h01};
        vecs[10] = '{4'b1000, 4'b0001, 1'b1, 8'hF8};
        vecs[11] = '{4'b1000, 4'b1000, 1'b0, 8'h40};

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy4), 32'd0);
        check("reset_done", 32'(done4), 32'd0);
        check("reset_p",    32'(p4),    32'd0);
        rst = 1'b0;

        // Directed table; first entry also starts in the first cycle after reset release.
        for (int i = 0; i < 12; i++) begin
            op4(vecs[i].x, vecs[i].y, vecs[i].sm, p, lat, bn);
            check($sformatf("vec%0d_p", i), 32'(p), 32'(vecs[i].exp_p));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bn), 32'd4);
            @(negedge clk);
            check($sformatf("vec%0d_hold_p", i), 32'(p4), 32'(vecs[i].exp_p));
            check($sformatf("vec%0d_done_low", i), 32'({busy4, done4}), 32'd0);
        end

        // Back-to-back: start held high throughout, operands change mid-CALC.
        start4 = 1'b1; x4 = 4'd3; y4 = 4'd5; sm4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        x4 = 4'd7; y4 = 4'd7;
        first_done = -1; second_done = -1;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (done4) begin
                if (first_done < 0) begin
                    first_done = cyc;
                    check("b2b_first_p", 32'(p4), 32'h0F);
                end else begin
                    second_done = cyc;
                    check("b2b_second_p", 32'(p4), 32'h31);
                    break;
                end
            end
            if (first_done > 0 && cyc == first_done + 1)
                check("b2b_hold_during_calc", 32'(p4), 32'h0F);
            @(negedge clk);
        end
        start4 = 1'b0;
        check("b2b_first_latency", 32'(first_done), 32'd5);
        check("b2b_gap", 32'(second_done - first_done), 32'd5);
        @(negedge clk);

        // Reset in the second CALC cycle aborts; no done afterwards.
        start4 = 1'b1; x4 = 4'd5; y4 = 4'd5; sm4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_done", 32'(done4), 32'd0);
        check("abort_p",    32'(p4),    32'd0);
        rst = 1'b0;
        late_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4) late_done++;
        end
        check("abort_no_done", 32'(late_done), 32'd0);

        // Reset wins over start; start in first cycle after release is accepted.
        rst = 1'b1; start4 = 1'b1; x4 = 4'd2; y4 = 4'd2;
        @(negedge clk);
        check("rst_priority_busy", 32'(busy4), 32'd0);
        rst = 1'b0;
        op4(4'd6, 4'd6, 1'b0, p, lat, bn);
        check("after_abort_p", 32'(p), 32'h24);
        check("after_abort_latency", 32'(lat), 32'd5);
        @(negedge clk);

        // Exhaustive N=4, both modes, chained back-to-back.
        for (int sm = 0; sm < 2; sm++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    op4(4'(x), 4'(y), 1'(sm), p, lat, bn);
                    check($sformatf("sweep4_m%0d_%0d_%0d", sm, x, y), 32'(p),
                          ref_prod(4, 16'(x), 16'(y), 1'(sm)));
                end
        @(negedge clk);

        // Random N=8 with extremes first.
        for (int i = 0; i < 300; i++) begin
            if (i == 0)      begin rx = 8'h80; ry = 8'h80; rsm = 1'b1; end
            else if (i == 1) begin rx = 8'h80; ry = 8'h7F; rsm = 1'b1; end
            else if (i == 2) begin rx = 8'hFF; ry = 8'hFF; rsm = 1'b0; end
            else begin rx = 8'($urandom); ry = 8'($urandom); rsm = 1'($urandom); end
            op8(rx, ry, rsm, pw, lat);
            check($sformatf("rand8_%0d", i), 32'(pw), ref_prod(8, 16'(rx), 16'(ry), rsm));
            if (i < 3) check($sformatf("rand8_latency_%0d", i), 32'(lat), 32'd9);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
